// File: rtl/rst_seq_ctrl.sv
// Reset release sequencer: releases NUM_DOMAINS active-low resets one at a time in index
// order, waiting for each domain's acknowledge, with timeout and lost-ack fault detection.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SW_RST_REQ,
    input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
    output logic [NUM_DOMAINS-1:0] RST_OUT,
    output logic                   SEQ_BUSY,
    output logic                   SEQ_DONE,
    output logic                   ERR_TIMEOUT,
    output logic                   ERR_ACK_LOST
);

    localparam int IDX_W = $clog2(NUM_DOMAINS);
    localparam int MAX_P = (HOLD_CYCLES > GAP_CYCLES)
                         ? ((HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT)
                         : ((GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT);
    localparam int CNT_W = $clog2(MAX_P + 32'sd1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 32'sd0) ? (GAP_CYCLES - 32'sd1) : 32'sd0);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 32'sd1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'sd1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(32'sd1);

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_ACK = 3'd1,
        ST_GAP      = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       idx_nxt_s;
    logic [NUM_DOMAINS-1:0] acked_mask_s;
    logic [NUM_DOMAINS-1:0] rel_mask_s;
    logic                   cur_ack_s;
    logic                   ack_lost_s;

    // Already-acked domain mask, next-release one-hot and the current domain's ack.
    always_comb begin
        acked_mask_s = {NUM_DOMAINS{1'b0}};
        rel_mask_s   = {NUM_DOMAINS{1'b0}};
        cur_ack_s    = 1'b0;
        idx_nxt_s    = idx_r + IDX_ONE;
        for (int j = 0; j < NUM_DOMAINS; j++) begin
            case (state_r)
                ST_WAIT_ACK:    acked_mask_s[j] = (j < int'(idx_r));
                ST_GAP, ST_RUN: acked_mask_s[j] = (j <= int'(idx_r));
                default:        acked_mask_s[j] = 1'b0;
            endcase
            rel_mask_s[j] = (j == int'(idx_nxt_s));
            if (j == int'(idx_r)) begin
                cur_ack_s = DOMAIN_ACK[j];
            end else begin
                cur_ack_s = cur_ack_s;
            end
        end
        ack_lost_s = |(acked_mask_s & ~DOMAIN_ACK);
    end

    // Sequencer state machine; every output is a register written here.
    always_ff @(posedge CLK) begin
        if (RST || SW_RST_REQ) begin
            state_r      <= ST_HOLD;
            idx_r        <= {IDX_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            RST_OUT      <= {NUM_DOMAINS{1'b0}};
            SEQ_BUSY     <= 1'b1;
            SEQ_DONE     <= 1'b0;
            ERR_TIMEOUT  <= 1'b0;
            ERR_ACK_LOST <= 1'b0;
        end else if (ack_lost_s) begin
            state_r      <= ST_FAULT;
            RST_OUT      <= {NUM_DOMAINS{1'b0}};
            SEQ_BUSY     <= 1'b0;
            SEQ_DONE     <= 1'b0;
            ERR_ACK_LOST <= 1'b1;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        RST_OUT[0] <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= ST_WAIT_ACK;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT_ACK: begin
                    // An ack sampled on the timeout edge still counts as on time.
                    if (cur_ack_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            state_r  <= ST_RUN;
                            SEQ_BUSY <= 1'b0;
                            SEQ_DONE <= 1'b1;
                        end else if (GAP_CYCLES == 32'sd0) begin
                            idx_r   <= idx_nxt_s;
                            RST_OUT <= RST_OUT | rel_mask_s;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end else if (cnt_r == ACK_LAST) begin
                        state_r     <= ST_FAULT;
                        RST_OUT     <= {NUM_DOMAINS{1'b0}};
                        SEQ_BUSY    <= 1'b0;
                        SEQ_DONE    <= 1'b0;
                        ERR_TIMEOUT <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        idx_r   <= idx_nxt_s;
                        RST_OUT <= RST_OUT | rel_mask_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_WAIT_ACK;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    RST_OUT <= {NUM_DOMAINS{1'b1}};
                end
                ST_FAULT: begin
                    RST_OUT  <= {NUM_DOMAINS{1'b0}};
                    SEQ_BUSY <= 1'b0;
                    SEQ_DONE <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: fail safe with every domain held in reset.
                    state_r  <= ST_FAULT;
                    RST_OUT  <= {NUM_DOMAINS{1'b0}};
                    SEQ_BUSY <= 1'b0;
                    SEQ_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule
